// File: rtl/fir_pkg.sv
// Shared definitions for the unfolded FIR front end: sample type, phase
// encoding and the unfolding factor.
package fir_pkg;

   localparam int NB  = 11;
   localparam int UNF = 3;

   typedef logic signed [NB-1:0] sample_t;

   typedef enum logic [1:0] {PH0, PH1, PH2} s2p_phase_t;

endpackage

// File: rtl/fir_s2p_unf_if.sv
// Serial sample stream in, parallel triplet stream out. The master side is
// the sample producer / triplet consumer, the slave side is the converter.
interface fir_s2p_unf_if;
   import fir_pkg::*;

   sample_t din;
   logic    vin;
   logic    flush;
   sample_t dout3k;
   sample_t dout3k1;
   sample_t dout3k2;
   logic    vout;
   logic    busy;

   modport master (
      output din, vin, flush,
      input  dout3k, dout3k1, dout3k2, vout, busy
   );

   modport slave (
      input  din, vin, flush,
      output dout3k, dout3k1, dout3k2, vout, busy
   );

endinterface

// File: rtl/fir_s2p_unf.sv
// Serial-to-parallel converter feeding the 3-way unfolded FIR. Collects
// three valid samples into a registered triplet with a one-cycle strobe;
// a flush zero-pads whatever partial triplet is being held.
module fir_s2p_unf
   import fir_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   fir_s2p_unf_if.slave bus
);

   s2p_phase_t phase;
   s2p_phase_t phase_nxt;
   sample_t    s0;
   sample_t    s1;
   logic       emit;
   sample_t    emit0;
   sample_t    emit1;
   sample_t    emit2;

   // Decode next phase and, when a triplet leaves, what goes in each slot.
   // Padding uses literal zeros so stale staging contents never escape.
   always_comb begin
      phase_nxt = phase;
      emit      = 1'b0;
      emit0     = s0;
      emit1     = s1;
      emit2     = bus.din;
      unique case (phase)
         PH0: begin
            if (bus.vin) begin
               if (bus.flush) begin
                  emit  = 1'b1;
                  emit0 = bus.din;
                  emit1 = '0;
                  emit2 = '0;
               end else begin
                  phase_nxt = PH1;
               end
            end
         end
         PH1: begin
            if (bus.vin) begin
               if (bus.flush) begin
                  emit      = 1'b1;
                  emit1     = bus.din;
                  emit2     = '0;
                  phase_nxt = PH0;
               end else begin
                  phase_nxt = PH2;
               end
            end else if (bus.flush) begin
               emit      = 1'b1;
               emit1     = '0;
               emit2     = '0;
               phase_nxt = PH0;
            end
         end
         PH2: begin
            if (bus.vin) begin
               emit      = 1'b1;
               phase_nxt = PH0;
            end else if (bus.flush) begin
               emit      = 1'b1;
               emit2     = '0;
               phase_nxt = PH0;
            end
         end
         default: begin
            phase_nxt = PH0;
         end
      endcase
   end

   // Phase register; reset mid-triplet simply drops the partial samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= PH0;
      end else begin
         phase <= phase_nxt;
      end
   end

   // Staging capture, triplet output registers and the emit strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0          <= '0;
         s1          <= '0;
         bus.dout3k  <= '0;
         bus.dout3k1 <= '0;
         bus.dout3k2 <= '0;
         bus.vout    <= 1'b0;
      end else begin
         if (bus.vin && phase == PH0) begin
            s0 <= bus.din;
         end
         if (bus.vin && phase == PH1) begin
            s1 <= bus.din;
         end
         if (emit) begin
            bus.dout3k  <= emit0;
            bus.dout3k1 <= emit1;
            bus.dout3k2 <= emit2;
         end
         bus.vout <= emit;
      end
   end

   assign bus.busy = (phase != PH0);

endmodule

// File: tb/tb_fir_s2p_unf.sv
// Bench for the serial-to-parallel FIR front end: directed vectors with
// literal expectations plus a queue-based model compared every cycle.
module tb_fir_s2p_unf;
   import fir_pkg::*;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFails;

   fir_s2p_unf_if bus ();

   fir_s2p_unf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: samples pile up in a list; three of them, or a flush with
   // anything pending, produce a zero-padded triplet and empty the list.
   sample_t pend[$];
   logic    mVout;
   logic    mBusy;
   sample_t mD0;
   sample_t mD1;
   sample_t mD2;

   initial begin
      mVout = 1'b0;
      mBusy = 1'b0;
      mD0   = '0;
      mD1   = '0;
      mD2   = '0;
   end

   // Model update on each active edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         mVout = 1'b0;
         mBusy = 1'b0;
         mD0   = '0;
         mD1   = '0;
         mD2   = '0;
      end else begin
         mVout = 1'b0;
         if (bus.vin) pend.push_back(bus.din);
         if (pend.size() == UNF || (bus.flush && pend.size() > 0)) begin
            while (pend.size() < UNF) pend.push_back('0);
            mD0   = pend[0];
            mD1   = pend[1];
            mD2   = pend[2];
            mVout = 1'b1;
            pend.delete();
         end
         mBusy = (pend.size() != 0);
      end
   end

   task automatic checkVal(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      checkVal("model.vout", int'(bus.vout), int'(mVout));
      checkVal("model.busy", int'(bus.busy), int'(mBusy));
      checkVal("model.dout3k", int'(bus.dout3k), int'(mD0));
      checkVal("model.dout3k1", int'(bus.dout3k1), int'(mD1));
      checkVal("model.dout3k2", int'(bus.dout3k2), int'(mD2));
   end

   // One cycle of input; returns just after the edge that consumed it.
   task automatic applyStimulus(input sample_t d, input logic v, input logic f);
      bus.din   = d;
      bus.vin   = v;
      bus.flush = f;
      @(posedge clk);
      #1;
      bus.vin   = 1'b0;
      bus.flush = 1'b0;
      bus.din   = '0;
   endtask

   task automatic checkOutput(input string name, input logic v, input int e0,
                              input int e1, input int e2, input logic b);
      checkVal({name, ".vout"}, int'(bus.vout), int'(v));
      checkVal({name, ".busy"}, int'(bus.busy), int'(b));
      checkVal({name, ".dout3k"}, int'(bus.dout3k), e0);
      checkVal({name, ".dout3k1"}, int'(bus.dout3k1), e1);
      checkVal({name, ".dout3k2"}, int'(bus.dout3k2), e2);
   endtask

   // Directed sequence.
   initial begin
      nChecks   = 0;
      nFails    = 0;
      rst_n     = 1'b0;
      bus.din   = '0;
      bus.vin   = 1'b0;
      bus.flush = 1'b0;
      #12;
      checkOutput("reset", 1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous stream, strobes three cycles apart.
      applyStimulus(11'sd1, 1'b1, 1'b0);
      applyStimulus(11'sd2, 1'b1, 1'b0);
      applyStimulus(11'sd3, 1'b1, 1'b0);
      checkOutput("cont.t1", 1'b1, 1, 2, 3, 1'b0);
      applyStimulus(11'sd4, 1'b1, 1'b0);
      checkOutput("cont.hold", 1'b0, 1, 2, 3, 1'b1);
      applyStimulus(11'sd5, 1'b1, 1'b0);
      applyStimulus(11'sd6, 1'b1, 1'b0);
      checkOutput("cont.t2", 1'b1, 4, 5, 6, 1'b0);

      // Gapped input keeps busy high through the holes.
      applyStimulus(11'sd10, 1'b1, 1'b0);
      applyStimulus(11'sd99, 1'b0, 1'b0);
      checkOutput("gap.g1", 1'b0, 4, 5, 6, 1'b1);
      applyStimulus(11'sd20, 1'b1, 1'b0);
      applyStimulus(11'sd99, 1'b0, 1'b0);
      applyStimulus(11'sd99, 1'b0, 1'b0);
      checkOutput("gap.g2", 1'b0, 4, 5, 6, 1'b1);
      applyStimulus(11'sd30, 1'b1, 1'b0);
      checkOutput("gap.t", 1'b1, 10, 20, 30, 1'b0);

      // Flush from PH2 without a sample, then a redundant flush.
      applyStimulus(-11'sd5, 1'b1, 1'b0);
      applyStimulus(11'sd7, 1'b1, 1'b0);
      applyStimulus(11'sd0, 1'b0, 1'b1);
      checkOutput("flush.ph2", 1'b1, -5, 7, 0, 1'b0);
      applyStimulus(11'sd0, 1'b0, 1'b1);
      checkOutput("flush.ph0", 1'b0, -5, 7, 0, 1'b0);

      // Sample and flush together in PH1.
      applyStimulus(11'sd100, 1'b1, 1'b0);
      applyStimulus(11'sd200, 1'b1, 1'b1);
      checkOutput("sim.ph1", 1'b1, 100, 200, 0, 1'b0);

      // Sample and flush together in PH0 and PH2; flush without sample in PH1.
      applyStimulus(11'sd55, 1'b1, 1'b1);
      checkOutput("sim.ph0", 1'b1, 55, 0, 0, 1'b0);
      applyStimulus(11'sd9, 1'b1, 1'b0);
      applyStimulus(11'sd0, 1'b0, 1'b1);
      checkOutput("flush.ph1", 1'b1, 9, 0, 0, 1'b0);
      applyStimulus(11'sd1, 1'b1, 1'b0);
      applyStimulus(11'sd2, 1'b1, 1'b0);
      applyStimulus(11'sd3, 1'b1, 1'b1);
      checkOutput("sim.ph2", 1'b1, 1, 2, 3, 1'b0);

      // Extremes: 0x3FF=1023, 0x400=-1024, 0x7FF=-1.
      applyStimulus(11'h3FF, 1'b1, 1'b0);
      applyStimulus(11'h400, 1'b1, 1'b0);
      applyStimulus(11'h7FF, 1'b1, 1'b0);
      checkOutput("extreme", 1'b1, 1023, -1024, -1, 1'b0);

      // Reset mid-triplet clears outputs at once; next triplet starts fresh.
      applyStimulus(11'sd8, 1'b1, 1'b0);
      applyStimulus(11'sd9, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst.async", 1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(11'sd11, 1'b1, 1'b0);
      checkOutput("rst.after1", 1'b0, 0, 0, 0, 1'b1);
      applyStimulus(11'sd12, 1'b1, 1'b0);
      applyStimulus(11'sd13, 1'b1, 1'b0);
      checkOutput("rst.after3", 1'b1, 11, 12, 13, 1'b0);

      // Mixed traffic checked only by the model.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(sample_t'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 5) == 0));
      end

      applyStimulus(11'sd0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
